// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: the instruction port (a) and the data port (b) share one
// downstream memory port. The data port wins ties; the granted request is held stable until pmem_resp.
module mem_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset_n,

    input  logic               cmem_read_a,
    input  logic               cmem_write_a,
    input  logic [WIDTH-1:0]   cmem_address_a,
    input  logic [WIDTH-1:0]   cmem_wdata_a,
    input  logic [WIDTH/8-1:0] cmem_byte_enable_a,
    output logic               cmem_resp_a,
    output logic [WIDTH-1:0]   cmem_rdata_a,

    input  logic               cmem_read_b,
    input  logic               cmem_write_b,
    input  logic [WIDTH-1:0]   cmem_address_b,
    input  logic [WIDTH-1:0]   cmem_wdata_b,
    input  logic [WIDTH/8-1:0] cmem_byte_enable_b,
    output logic               cmem_resp_b,
    output logic [WIDTH-1:0]   cmem_rdata_b,

    output logic               pmem_read,
    output logic               pmem_write,
    output logic [WIDTH-1:0]   pmem_address,
    output logic [WIDTH-1:0]   pmem_wdata,
    output logic [WIDTH/8-1:0] pmem_byte_enable,
    input  logic               pmem_resp,
    input  logic [WIDTH-1:0]   pmem_rdata
);

    localparam int BE_W = WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_A = 2'd1,
        SERVE_B = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic              read_reg, read_next;
    logic              write_reg, write_next;
    logic [WIDTH-1:0]  address_reg, address_next;
    logic [WIDTH-1:0]  wdata_reg, wdata_next;
    logic [BE_W-1:0]   be_reg, be_next;

    logic pending_a, pending_b;
    logic load_a, load_b, clear_req;

    assign pending_a = cmem_read_a | cmem_write_a;
    assign pending_b = cmem_read_b | cmem_write_b;

    // On a completion edge the granted port's own request is ignored so a port that keeps
    // its request high cannot be re-granted back to back without an IDLE cycle.
    always_comb begin
        state_next = state_reg;
        load_a     = 1'b0;
        load_b     = 1'b0;
        clear_req  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (pending_b) begin
                    state_next = SERVE_B;
                    load_b     = 1'b1;
                end else if (pending_a) begin
                    state_next = SERVE_A;
                    load_a     = 1'b1;
                end
            end
            SERVE_A: begin
                if (pmem_resp) begin
                    if (pending_b) begin
                        state_next = SERVE_B;
                        load_b     = 1'b1;
                    end else begin
                        state_next = IDLE;
                        clear_req  = 1'b1;
                    end
                end
            end
            SERVE_B: begin
                if (pmem_resp) begin
                    if (pending_a) begin
                        state_next = SERVE_A;
                        load_a     = 1'b1;
                    end else begin
                        state_next = IDLE;
                        clear_req  = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                clear_req  = 1'b1;
            end
        endcase
    end

    // A simultaneous read and write is latched as a write only.
    always_comb begin
        read_next    = read_reg;
        write_next   = write_reg;
        address_next = address_reg;
        wdata_next   = wdata_reg;
        be_next      = be_reg;
        if (load_b) begin
            read_next    = cmem_read_b & ~cmem_write_b;
            write_next   = cmem_write_b;
            address_next = cmem_address_b;
            wdata_next   = cmem_wdata_b;
            be_next      = cmem_byte_enable_b;
        end else if (load_a) begin
            read_next    = cmem_read_a & ~cmem_write_a;
            write_next   = cmem_write_a;
            address_next = cmem_address_a;
            wdata_next   = cmem_wdata_a;
            be_next      = cmem_byte_enable_a;
        end else if (clear_req) begin
            read_next  = 1'b0;
            write_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            read_reg    <= 1'b0;
            write_reg   <= 1'b0;
            address_reg <= '0;
            wdata_reg   <= '0;
            be_reg      <= '0;
        end else begin
            state_reg   <= state_next;
            read_reg    <= read_next;
            write_reg   <= write_next;
            address_reg <= address_next;
            wdata_reg   <= wdata_next;
            be_reg      <= be_next;
        end
    end

    assign pmem_read        = read_reg;
    assign pmem_write       = write_reg;
    assign pmem_address     = address_reg;
    assign pmem_wdata       = wdata_reg;
    assign pmem_byte_enable = be_reg;

    assign cmem_resp_a  = (state_reg == SERVE_A) & pmem_resp;
    assign cmem_resp_b  = (state_reg == SERVE_B) & pmem_resp;
    assign cmem_rdata_a = pmem_rdata;
    assign cmem_rdata_b = pmem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requests are queued per port as issued, and a negedge
// monitor grants them by the priority rule and checks every downstream/upstream output.
module tb_mem_arbiter;

    localparam int W  = 32;
    localparam int BW = W / 8;

    logic          clk     = 1'b0;
    logic          reset_n = 1'b0;

    logic          cmem_read_a = 1'b0, cmem_write_a = 1'b0;
    logic [W-1:0]  cmem_address_a = '0, cmem_wdata_a = '0;
    logic [BW-1:0] cmem_byte_enable_a = '0;
    logic          cmem_resp_a;
    logic [W-1:0]  cmem_rdata_a;

    logic          cmem_read_b = 1'b0, cmem_write_b = 1'b0;
    logic [W-1:0]  cmem_address_b = '0, cmem_wdata_b = '0;
    logic [BW-1:0] cmem_byte_enable_b = '0;
    logic          cmem_resp_b;
    logic [W-1:0]  cmem_rdata_b;

    logic          pmem_read, pmem_write;
    logic [W-1:0]  pmem_address, pmem_wdata;
    logic [BW-1:0] pmem_byte_enable;
    logic          pmem_resp = 1'b0;
    logic [W-1:0]  pmem_rdata = '0;

    mem_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmem_read_a(cmem_read_a), .cmem_write_a(cmem_write_a),
        .cmem_address_a(cmem_address_a), .cmem_wdata_a(cmem_wdata_a),
        .cmem_byte_enable_a(cmem_byte_enable_a),
        .cmem_resp_a(cmem_resp_a), .cmem_rdata_a(cmem_rdata_a),
        .cmem_read_b(cmem_read_b), .cmem_write_b(cmem_write_b),
        .cmem_address_b(cmem_address_b), .cmem_wdata_b(cmem_wdata_b),
        .cmem_byte_enable_b(cmem_byte_enable_b),
        .cmem_resp_b(cmem_resp_b), .cmem_rdata_b(cmem_rdata_b),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_byte_enable(pmem_byte_enable),
        .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rd;
        logic          wr;
        logic [W-1:0]  addr;
        logic [W-1:0]  wdata;
        logic [BW-1:0] be;
        int            issued;
    } req_t;

    req_t q_a[$];
    req_t q_b[$];
    req_t cur_req;
    int   cur = 0;          // port the memory is serving: 0 none, 1 A, 2 B
    bit   last_resp = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;

    bit   busy [3];
    int   lat = 0;
    int   fixed_lat = -1;
    bit   rand_en = 1'b0;
    int   spur_pct = 0;
    bit   use_fix = 1'b0;
    logic [W-1:0] fix_rdata = '0;
    bit   garble_a = 1'b0;
    logic [W-1:0] next_a[$];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: retire, grant (data port first, only requests seen at an earlier edge), compare.
    initial forever begin
        @(negedge clk);
        if (!reset_n) begin
            check("rst_pmem_read",  W'(pmem_read), '0);
            check("rst_pmem_write", W'(pmem_write), '0);
            check("rst_pmem_addr",  pmem_address, '0);
            check("rst_pmem_wdata", pmem_wdata, '0);
            check("rst_pmem_be",    W'(pmem_byte_enable), '0);
            check("rst_resp_a",     W'(cmem_resp_a), '0);
            check("rst_resp_b",     W'(cmem_resp_b), '0);
            cur       = 0;
            last_resp = 1'b0;
        end else begin
            if (last_resp && cur != 0) begin
                $display("done  port %s cycle %0d", (cur == 1) ? "A" : "B", cyc);
                cur = 0;
            end
            if (cur == 0) begin
                if (q_b.size() > 0 && q_b[0].issued < cyc) begin
                    cur = 2;
                    cur_req = q_b.pop_front();
                end else if (q_a.size() > 0 && q_a[0].issued < cyc) begin
                    cur = 1;
                    cur_req = q_a.pop_front();
                end
                if (cur != 0)
                    $display("grant port %s rd=%0b wr=%0b addr=%h cycle %0d",
                             (cur == 1) ? "A" : "B", cur_req.rd, cur_req.wr, cur_req.addr, cyc);
            end
            if (cur != 0) begin
                check("pmem_read",  W'(pmem_read), W'(cur_req.rd & ~cur_req.wr));
                check("pmem_write", W'(pmem_write), W'(cur_req.wr));
                check("pmem_addr",  pmem_address, cur_req.addr);
                check("pmem_wdata", pmem_wdata, cur_req.wdata);
                check("pmem_be",    W'(pmem_byte_enable), W'(cur_req.be));
            end else begin
                check("idle_pmem_read",  W'(pmem_read), '0);
                check("idle_pmem_write", W'(pmem_write), '0);
            end
            check("resp_a",  W'(cmem_resp_a), W'(cur == 1 && pmem_resp));
            check("resp_b",  W'(cmem_resp_b), W'(cur == 2 && pmem_resp));
            check("rdata_a", cmem_rdata_a, pmem_rdata);
            check("rdata_b", cmem_rdata_b, pmem_rdata);
            last_resp = pmem_resp;
        end
    end

    task automatic drive(input int p, input logic rd, input logic wr, input logic [W-1:0] addr,
                         input logic [W-1:0] wd, input logic [BW-1:0] be);
        if (p == 1) begin
            cmem_read_a = rd; cmem_write_a = wr; cmem_address_a = addr;
            cmem_wdata_a = wd; cmem_byte_enable_a = be;
        end else begin
            cmem_read_b = rd; cmem_write_b = wr; cmem_address_b = addr;
            cmem_wdata_b = wd; cmem_byte_enable_b = be;
        end
    endtask

    task automatic issue(input int p, input logic rd, input logic wr, input logic [W-1:0] addr,
                         input logic [W-1:0] wd, input logic [BW-1:0] be);
        req_t r;
        r.rd = rd; r.wr = wr; r.addr = addr; r.wdata = wd; r.be = be; r.issued = cyc;
        drive(p, rd, wr, addr, wd, be);
        if (p == 1) q_a.push_back(r);
        else        q_b.push_back(r);
        busy[p] = 1'b1;
        $display("issue port %s rd=%0b wr=%0b addr=%h cycle %0d", (p == 1) ? "A" : "B", rd, wr, addr, cyc);
    endtask

    task automatic drop(input int p);
        drive(p, 1'b0, 1'b0, '0, '0, '0);
        busy[p] = 1'b0;
    endtask

    task automatic issue_rand(input int p);
        int kind;
        kind = $urandom_range(0, 2);
        issue(p, kind != 1, kind != 0, $urandom, $urandom, BW'($urandom));
    endtask

    // Scribble over the port while it is being served; the latched request must not change.
    task automatic garble(input int p);
        bit keep;
        keep = 1'($urandom_range(0, 1));
        drive(p, keep & 1'($urandom_range(0, 1)), keep & 1'($urandom_range(0, 1)),
              $urandom, $urandom, BW'($urandom));
    endtask

    function automatic int pick_lat();
        return (fixed_lat < 0) ? int'($urandom_range(0, 3)) : fixed_lat;
    endfunction

    task automatic port_step(input int p, input bit done, input bit serving);
        if (rand_en) begin
            if (done) begin
                if ($urandom_range(0, 1) == 1) issue_rand(p);
                else drop(p);
            end else if (!busy[p]) begin
                if ($urandom_range(0, 99) < 30) issue_rand(p);
            end else if (serving && $urandom_range(0, 3) == 0) begin
                garble(p);
            end
        end else if (done) begin
            if (p == 1 && next_a.size() > 0) issue(1, 1'b1, 1'b0, next_a.pop_front(), '0, '1);
            else drop(p);
        end else if (p == 1 && serving && garble_a) begin
            drive(1, 1'b0, 1'b0, 32'hBAD0_0000, '0, '0);
        end
    endtask

    // One clock of stimulus: memory responder plus both requesters, driven 1 time unit after the edge.
    task automatic step();
        int cur_pre;
        bit resp_pre;
        @(negedge clk);
        #1;
        cur_pre  = cur;
        resp_pre = pmem_resp;
        @(posedge clk);
        #1;
        pmem_rdata = use_fix ? fix_rdata : W'($urandom);
        if (resp_pre) begin
            pmem_resp = 1'b0;
            lat = pick_lat();
        end else if (cur_pre != 0) begin
            if (lat == 0) pmem_resp = 1'b1;
            else lat--;
        end else begin
            lat = pick_lat();
            if ($urandom_range(0, 99) < spur_pct) pmem_resp = 1'b1;
        end
        port_step(1, resp_pre && cur_pre == 1, cur_pre == 1);
        port_step(2, resp_pre && cur_pre == 2, cur_pre == 2);
    endtask

    task automatic wait_quiet(input int max, input string name);
        int n;
        n = 0;
        while ((busy[1] || busy[2] || cur != 0 || q_a.size() > 0 || q_b.size() > 0) && n < max) begin
            step();
            n++;
        end
        check(name, W'(n < max), W'(1));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Single read on A with a fixed response value.
        use_fix = 1'b1; fix_rdata = 32'hDEADBEEF; fixed_lat = 2;
        issue(1, 1'b1, 1'b0, 32'h100, '0, '1);
        wait_quiet(40, "single_read_done");
        use_fix = 1'b0;

        // Simultaneous A read / B write: B first, then A without an idle gap.
        issue(1, 1'b1, 1'b0, 32'h200, '0, '1);
        issue(2, 1'b0, 1'b1, 32'h300, 32'h12345678, 4'b0011);
        wait_quiet(40, "simultaneous_done");

        // A reads continuously, stepping the address.
        next_a.push_back(32'h4);
        next_a.push_back(32'h8);
        issue(1, 1'b1, 1'b0, 32'h0, '0, '1);
        wait_quiet(60, "continuous_done");

        // A drops its request and changes address while served.
        garble_a = 1'b1;
        issue(1, 1'b1, 1'b0, 32'h500, '0, '1);
        wait_quiet(40, "stability_done");
        garble_a = 1'b0;

        // Both read and write on B latches as a write.
        issue(2, 1'b1, 1'b1, 32'h600, 32'hA5A5_5A5A, 4'b1100);
        wait_quiet(40, "rw_both_done");

        // Spurious responses while idle.
        spur_pct = 100;
        repeat (6) step();
        spur_pct = 0;

        // Randomized traffic.
        fixed_lat = -1; rand_en = 1'b1; spur_pct = 5;
        repeat (3000) step();
        rand_en = 1'b0; spur_pct = 0;
        wait_quiet(60, "random_drain");

        // Reset while serving B, with a response arriving during reset.
        fixed_lat = 10;
        issue(2, 1'b0, 1'b1, 32'h700, 32'hCAFE0001, 4'hF);
        begin
            int n;
            n = 0;
            while (cur != 2 && n < 20) begin
                step();
                n++;
            end
        end
        check("reach_serve_b", W'(cur == 2), W'(1));
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        drop(1); drop(2);
        q_a.delete(); q_b.delete();
        pmem_resp = 1'b1;
        @(posedge clk);
        #1;
        pmem_resp = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        lat = 0;
        repeat (3) step();

        // Arbitration resumes normally after reset.
        fixed_lat = 1;
        issue(1, 1'b1, 1'b0, 32'h800, '0, '1);
        wait_quiet(40, "post_reset_done");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 32, the address and data width in bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 cmem_read_a / cmem_write_a  input  1 each  instruction-port read and write requests.
REQ-005 cmem_address_a / cmem_wdata_a  input  WIDTH each  instruction-port address and write data.
REQ-006 cmem_byte_enable_a  input  WIDTH/8  instruction-port byte enables.
REQ-007 cmem_resp_a  output  1  instruction-port completion pulse.
REQ-008 cmem_rdata_a  output  WIDTH  instruction-port read data.
REQ-009 cmem_read_b, cmem_write_b, cmem_address_b, cmem_wdata_b, cmem_byte_enable_b, cmem_resp_b and cmem_rdata_b SHALL match the port-a signals in direction and width, for the data port.
REQ-010 pmem_read / pmem_write  output  1 each  downstream read and write requests.
REQ-011 pmem_address / pmem_wdata  output  WIDTH each  downstream address and write data.
REQ-012 pmem_byte_enable  output  WIDTH/8  downstream byte enables.
REQ-013 pmem_resp  input  1  downstream completion pulse.
REQ-014 pmem_rdata  input  WIDTH  downstream read data.

Function
REQ-015 A port SHALL be pending when its read or its write is high.
REQ-016 The FSM SHALL have three states: IDLE, SERVE_A and SERVE_B.
REQ-017 In IDLE:
- both ports pending -> SERVE_B (data has priority);
- only A pending -> SERVE_A;
- only B pending -> SERVE_B;
- none pending -> stay in IDLE.
REQ-018 On the edge that enters a SERVE state, the block SHALL latch the granted port's read, write, address, wdata and byte_enable into registers that drive the pmem_* outputs.
- pmem_read/pmem_write are therefore first high one cycle after the request is seen in IDLE.
REQ-019 If the granted port asserts read and write together, the block SHALL latch write=1 and read=0.
REQ-020 pmem_* outputs SHALL hold constant for the whole SERVE state, whatever the granted port does meanwhile.
REQ-021 In SERVE_x without pmem_resp, the FSM SHALL stay in SERVE_x.
REQ-022 In SERVE_x with pmem_resp high:
- cmem_resp_x SHALL be high in that same cycle (combinational);
- cmem_rdata_x SHALL equal pmem_rdata in that cycle.
REQ-023 On the pmem_resp edge, the granted port's own request SHALL be ignored, because it may still be high (port a reads continuously).
- Other port pending -> go directly to the other SERVE state, latching that port's request on this edge.
- Otherwise -> go to IDLE, with pmem_read and pmem_write cleared.
REQ-024 cmem_resp_x SHALL be 0 whenever the FSM is not in SERVE_x or pmem_resp is low.
REQ-025 cmem_rdata_a and cmem_rdata_b SHALL always carry pmem_rdata, qualified only by resp.
REQ-026 A request dropped mid-transaction SHALL NOT abort it; the transaction completes and resp still pulses.
REQ-027 pmem_resp seen while in IDLE SHALL be ignored and SHALL cause no cmem_resp.
REQ-028 Each port SHALL have at most one outstanding transaction; nothing is buffered beyond the latched request.

Reset
REQ-029 While reset_n is low:
- state = IDLE;
- pmem_read = pmem_write = 0;
- pmem_address, pmem_wdata and pmem_byte_enable = 0;
- cmem_resp_a = cmem_resp_b = 0.
REQ-030 Asserting reset_n mid-transaction SHALL abandon the transaction immediately, with no resp pulse.
REQ-031 After reset_n deasserts, arbitration SHALL resume from IDLE on the first rising edge.

Verification
REQ-032 Single read on A:
- stimulus: address_a=0x100; pmem_resp asserted 3 cycles after pmem_read, with pmem_rdata=0xDEADBEEF;
- response: pmem_address=0x100 one cycle after the request; cmem_resp_a pulses exactly 1 cycle with rdata 0xDEADBEEF; cmem_resp_b stays 0.
REQ-033 Simultaneous requests:
- stimulus: A reads 0x200 and B writes 0x300 with wdata=0x12345678, byte_enable=4'b0011, both raised in the same cycle;
- response: B served first (pmem_write=1, pmem_wdata=0x12345678, pmem_byte_enable=4'b0011); on B's resp edge the FSM goes straight to SERVE_A with pmem_address=0x200, with no IDLE cycle between.
REQ-034 Continuous A:
- stimulus: read_a held at 1 with the address stepping 0x0, 0x4, 0x8, and B idle;
- response: three separate pmem_read transactions, one IDLE cycle between each, with addresses 0x0, 0x4 and 0x8 in order.
REQ-035 Reset mid-transaction:
- stimulus: reset_n driven low while in SERVE_B, with pmem_resp arriving during reset;
- response: all outputs 0, no cmem_resp_b, state IDLE after release.
REQ-036 Request stability:
- stimulus: address_a changed and read_a dropped while in SERVE_A;
- response: pmem_address unchanged, and cmem_resp_a still pulses on pmem_resp.
REQ-037 Spurious response:
- stimulus: pmem_resp pulsed while in IDLE;
- response: no cmem_resp on either port, and no state change.
